// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types: PC/instruction words, fetch FSM encoding, reset vector.
// Also holds the registered instruction-output record and PC helpers.
package rv32_pkg;

  typedef logic [31:0] rv32_pc_cnt_t;
  typedef logic [31:0] rv32_instr_t;

  localparam rv32_pc_cnt_t RV32_RESET_PC = 32'h0000_0000;
  localparam rv32_pc_cnt_t RV32_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_DRAIN    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic         valid;
    rv32_instr_t  instr;
    rv32_pc_cnt_t pc;
  } fetch_out_t;

  function automatic rv32_pc_cnt_t pc_align(input rv32_pc_cnt_t pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic pc_misaligned(input rv32_pc_cnt_t pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rv32_fetch.sv
// RV32 instruction fetch: one outstanding imem request, registered instruction output,
// redirect with stale-response drain and misaligned-target flag.
module rv32_fetch
  import rv32_pkg::*;
#(
  parameter rv32_pc_cnt_t RESET_PC = RV32_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rv32_has_new_pc,
  input  rv32_pc_cnt_t rv32_next_pc_val,
  input  logic         rv32_stall,
  output logic         imem_req_valid,
  output rv32_pc_cnt_t imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  rv32_instr_t  imem_rsp_data,
  output logic         rv32_instr_valid,
  output rv32_instr_t  rv32_instr,
  output rv32_pc_cnt_t rv32_instr_pc,
  output logic         rv32_misalign_err
);

  fetch_state_e state, state_nxt;
  rv32_pc_cnt_t pc, req_pc;
  fetch_out_t   out_q;
  logic         misalign_q;
  logic         req_fire, rsp_load, consume;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  // An accepted request whose result is no longer wanted must be drained
  // before the next request, keeping at most one in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FETCH:    if (req_fire) state_nxt = rv32_has_new_pc ? ST_DRAIN : ST_WAIT_RSP;
      ST_WAIT_RSP: if (imem_rsp_valid)       state_nxt = ST_FETCH;
                   else if (rv32_has_new_pc) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (imem_rsp_valid)       state_nxt = ST_FETCH;
      default:     state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req_valid = !rst && (state == ST_FETCH) && !(out_q.valid && rv32_stall);
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_load       = (state == ST_WAIT_RSP) && imem_rsp_valid && !rv32_has_new_pc;
    consume        = out_q.valid && !rv32_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      req_pc     <= '0;
      out_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= rv32_has_new_pc && pc_misaligned(rv32_next_pc_val);
      if (rv32_has_new_pc) pc <= pc_align(rv32_next_pc_val);
      else if (req_fire)   pc <= pc + RV32_PC_STEP;
      if (req_fire) req_pc <= pc;
      // Redirect squashes both the held instruction and any same-edge response.
      if (rv32_has_new_pc)  out_q.valid <= 1'b0;
      else if (rsp_load)    out_q <= '{valid: 1'b1, instr: imem_rsp_data, pc: req_pc};
      else if (consume)     out_q.valid <= 1'b0;
    end
  end

  assign rv32_instr_valid  = out_q.valid;
  assign rv32_instr        = out_q.instr;
  assign rv32_instr_pc     = out_q.pc;
  assign rv32_misalign_err = misalign_q;

endmodule
